// File: rtl/serial_pkg.sv
// Shared definitions for the serial channel mux/demux: FSM encoding, header
// byte layout and the round-robin search used on both ends of the link.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam logic [3:0] HDR_TAG_DEF = 4'hA;
    localparam int         MAX_N       = 16;

    function automatic logic [7:0] hdr_byte(input logic [3:0] tag, input logic [3:0] id);
        return {tag, id};
    endfunction

    // First set bit of mask scanning last+1 .. last+n (mod n); returns last if none.
    function automatic logic [3:0] rr_next(input logic [MAX_N-1:0] mask,
                                           input logic [3:0]       last,
                                           input int               n);
        logic [3:0] idx;
        logic       found;
        int         cand;
        idx   = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_N; k++) begin
            cand = (int'(last) + k) % n;
            if (k <= n && !found && mask[cand[3:0]]) begin
                idx   = cand[3:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/serial_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: lowest-priority index is last_i, search
// starts at last_i+1 and wraps.
module rr_picker
    import serial_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [3:0]   last_i,
    output logic [3:0]   idx_o,
    output logic         found_o
);

    logic [MAX_N-1:0] mask;

    always_comb begin
        mask         = '0;
        mask[N-1:0]  = req_i;
        idx_o        = rr_next(mask, last_i, N);
        found_o      = |req_i;
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Packet-granular round-robin mux of N byte streams onto one SerialTransmitter,
// optional channel header per packet, 1 byte per 2 cycles peak, stall timeout abort.
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter int         N         = 4,
    parameter logic [3:0] HDR_TAG   = HDR_TAG_DEF,
    parameter int         HEADER_EN = 1,
    parameter int         TIMEOUT   = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_valid,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [7:0]     tx_data,
    output logic           tx_write,
    input  logic           tx_ready,
    output logic [3:0]     grant_id,
    output logic           busy,
    output logic           abort
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    state_e        ret_q, ret_d;
    logic [3:0]    gid_q, gid_d;
    logic [3:0]    last_q, last_d;
    logic [7:0]    dat_q, dat_d;
    logic          wr_q, wr_d;
    logic          abort_q, abort_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [3:0]    pick;
    logic          pick_vld;
    logic [N-1:0]  gmask;
    logic [7:0]    g_data;
    logic          g_valid;
    logic          g_last;
    logic          hs;

    rr_picker #(.N(N)) u_rr_picker (
        .req_i   (req_valid),
        .last_i  (last_q),
        .idx_o   (pick),
        .found_o (pick_vld)
    );

    always_comb begin
        gmask   = {{(N-1){1'b0}}, 1'b1} << gid_q;
        g_valid = |(req_valid & gmask);
        g_last  = |(req_last & gmask);
        g_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (gid_q == 4'(i)) g_data = req_data[8*i +: 8];
        end
        req_ready = (state_q == ST_DATA && tx_ready) ? gmask : '0;
        hs        = (state_q == ST_DATA) && tx_ready && g_valid;
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        gid_d   = gid_q;
        last_d  = last_q;
        dat_d   = dat_q;
        wr_d    = 1'b0;
        abort_d = 1'b0;
        tmo_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gid_d   = pick;
                    last_d  = pick;
                    state_d = (HEADER_EN != 0) ? ST_HDR : ST_DATA;
                end
            end
            ST_HDR: begin
                if (tx_ready) begin
                    dat_d   = hdr_byte(HDR_TAG, gid_q);
                    wr_d    = 1'b1;
                    ret_d   = ST_DATA;
                    state_d = ST_HOLD;
                end
            end
            ST_DATA: begin
                if (hs) begin
                    dat_d   = g_data;
                    wr_d    = 1'b1;
                    ret_d   = g_last ? ST_IDLE : ST_DATA;
                    state_d = ST_HOLD;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    // last_grant keeps the aborted id so it drops to lowest priority
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_HOLD: begin
                state_d = ret_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_IDLE;
            gid_q   <= '0;
            last_q  <= 4'(N - 1);
            dat_q   <= '0;
            wr_q    <= 1'b0;
            abort_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            dat_q   <= dat_d;
            wr_q    <= wr_d;
            abort_q <= abort_d;
            tmo_q   <= tmo_d;
        end
    end

    assign tx_data  = dat_q;
    assign tx_write = wr_q;
    assign grant_id = gid_q;
    assign busy     = (state_q != ST_IDLE);
    assign abort    = abort_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: event-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_serial_tx_arbiter;

    localparam int         N   = 4;
    localparam int         TMO = 16;
    localparam logic [3:0] TAG = 4'hA;
    localparam int         HEN = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [7:0]     tx_data;
    logic           tx_write, tx_ready;
    logic [3:0]     grant_id;
    logic           busy, abort;

    logic [8*N-1:0] b_data;
    logic [N-1:0]   b_valid, b_last, b_ready;
    logic [7:0]     b_tx_data;
    logic           b_tx_write;
    logic [3:0]     b_gid;
    logic           b_busy, b_abort;

    always #5 clk = ~clk;

    serial_tx_arbiter #(.N(N), .HDR_TAG(TAG), .HEADER_EN(1), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
        .tx_write(tx_write), .tx_ready(tx_ready), .grant_id(grant_id),
        .busy(busy), .abort(abort)
    );

    serial_tx_arbiter #(.N(N), .HDR_TAG(TAG), .HEADER_EN(0), .TIMEOUT(1024)) dut_nohdr (
        .clk(clk), .rst(rst), .req_data(b_data), .req_valid(b_valid),
        .req_last(b_last), .req_ready(b_ready), .tx_data(b_tx_data),
        .tx_write(b_tx_write), .tx_ready(1'b1), .grant_id(b_gid),
        .busy(b_busy), .abort(b_abort)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Stimulus queues: {last, byte}
    logic [8:0] pq [N][$];
    logic [8:0] bq [$];
    int         vld_pct = 100;
    int         rdy_pct = 100;
    logic [N-1:0] drop = '0;

    // Observation logs
    logic [7:0] slog_d [$];
    int         slog_c [$];
    logic [7:0] blog_d [$];
    int         blog_c [$];
    int         abort_c [$];
    logic       abort_busy [$];

    // Reference model: transaction timeline in absolute cycle numbers
    int         m_owner, m_last, m_free_at, m_ready_from, m_end_at, m_stall;
    logic [3:0] m_gid;
    logic [7:0] m_dat;
    logic       m_wr, m_abort, m_hdr_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_model(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = N - 1; m_gid = '0; m_dat = '0;
        m_wr = 1'b0; m_abort = 1'b0; m_free_at = 0; m_ready_from = 0;
        m_end_at = -1; m_hdr_done = 1'b0; m_stall = 0;
    endtask

    task automatic clear_logs();
        slog_d.delete(); slog_c.delete(); blog_d.delete(); blog_c.delete();
        abort_c.delete(); abort_busy.delete();
    endtask

    task automatic drive(input logic [N-1:0] hs, input logic [N-1:0] bhs);
        for (int i = 0; i < N; i++) begin
            if (hs[i] && pq[i].size() > 0) void'(pq[i].pop_front());
            if (pq[i].size() > 0 && !drop[i] && $urandom_range(99) < vld_pct) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = pq[i][0][7:0];
                req_last[i]        = pq[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
        tx_ready = ($urandom_range(99) < rdy_pct);
        if (bhs[1] && bq.size() > 0) void'(bq.pop_front());
        b_valid = '0; b_last = '0; b_data = '0;
        if (bq.size() > 0) begin
            b_valid[1]    = 1'b1;
            b_data[15:8]  = bq[0][7:0];
            b_last[1]     = bq[0][8];
        end
    endtask

    task automatic kick();
        drive('0, '0);
    endtask

    // One clock: compare at negedge against the model, advance the model, drive at posedge+1.
    task automatic step();
        logic [N-1:0] exp_rdy, hs, bhs;
        int p;
        @(negedge clk);
        cyc++;
        if (b_tx_write) begin blog_d.push_back(b_tx_data); blog_c.push_back(cyc); end
        chk("nohdr_abort", b_abort, 0);
        if (rst) begin
            model_reset();
            chk("rst_outputs", {tx_data, tx_write, grant_id, busy, abort, req_ready}, 0);
        end else begin
            if (m_end_at == cyc) m_owner = -1;
            exp_rdy = '0;
            if (m_owner >= 0 && m_end_at < 0 && cyc >= m_ready_from && m_hdr_done && tx_ready)
                exp_rdy = N'(1) << m_owner;
            chk("tx_write", tx_write, m_wr);
            chk("tx_data", tx_data, m_dat);
            chk("abort", abort, m_abort);
            chk("busy", busy, m_owner >= 0);
            chk("grant_id", grant_id, m_gid);
            chk("req_ready", req_ready, exp_rdy);
            if (tx_write) begin slog_d.push_back(tx_data); slog_c.push_back(cyc); end
            if (abort) begin abort_c.push_back(cyc); abort_busy.push_back(busy); end
            m_wr = 1'b0;
            m_abort = 1'b0;
            if (m_owner < 0) begin
                if (cyc >= m_free_at && req_valid != '0) begin
                    p = rr_model(req_valid, m_last);
                    m_owner = p; m_last = p; m_gid = 4'(p);
                    m_ready_from = cyc + 1; m_hdr_done = (HEN == 0);
                    m_stall = 0; m_end_at = -1;
                end
            end else if (m_end_at < 0 && cyc >= m_ready_from) begin
                if (!m_hdr_done) begin
                    if (tx_ready) begin
                        m_wr = 1'b1; m_dat = {TAG, 4'(m_owner)};
                        m_hdr_done = 1'b1; m_ready_from = cyc + 2;
                    end
                end else if (req_valid[m_owner] && tx_ready) begin
                    m_wr = 1'b1; m_dat = req_data[8*m_owner +: 8];
                    m_stall = 0; m_ready_from = cyc + 2;
                    if (req_last[m_owner]) begin m_end_at = cyc + 2; m_free_at = cyc + 2; end
                end else begin
                    m_stall++;
                    if (m_stall == TMO) begin
                        m_abort = 1'b1; m_end_at = cyc + 1; m_free_at = cyc + 1; m_stall = 0;
                    end
                end
            end
        end
        hs  = req_valid & req_ready;
        bhs = b_valid & b_ready;
        @(posedge clk);
        #1;
        drive(hs, bhs);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) pq[i].delete();
        bq.delete();
        drop = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int c0, h, remaining, found;
        rst = 1'b1;
        req_data = '0; req_valid = '0; req_last = '0; tx_ready = 1'b1;
        b_data = '0; b_valid = '0; b_last = '0;
        model_reset();
        do_reset();

        // Reset values
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_tx_write", tx_write, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_grant_id", grant_id, 0);
        chk("reset_abort", abort, 0);
        chk("reset_req_ready", req_ready, 0);

        // Single packet from requester 2
        vld_pct = 100; rdy_pct = 100; clear_logs();
        pq[2].push_back({1'b0, 8'h68});
        pq[2].push_back({1'b1, 8'h69});
        kick(); c0 = cyc + 1;
        repeat (10) step();
        chk("single_count", slog_d.size(), 3);
        if (slog_d.size() >= 3) begin
            chk("single_hdr", slog_d[0], 8'hA2);
            chk("single_b0", slog_d[1], 8'h68);
            chk("single_b1", slog_d[2], 8'h69);
            chk("single_t0", slog_c[0], c0 + 2);
            chk("single_t1", slog_c[1], c0 + 4);
            chk("single_t2", slog_c[2], c0 + 6);
        end
        chk("single_idle_after", busy, 0);

        // Contention 0,1,3 from reset pointer
        do_reset(); clear_logs();
        pq[0].push_back({1'b1, 8'h10});
        pq[1].push_back({1'b1, 8'h11});
        pq[3].push_back({1'b1, 8'h13});
        kick();
        repeat (24) step();
        chk("cont_count", slog_d.size(), 6);
        if (slog_d.size() >= 6) begin
            chk("cont_hdr0", slog_d[0], 8'hA0);
            chk("cont_d0", slog_d[1], 8'h10);
            chk("cont_hdr1", slog_d[2], 8'hA1);
            chk("cont_hdr3", slog_d[4], 8'hA3);
            chk("cont_d3", slog_d[5], 8'h13);
        end
        clear_logs();
        pq[0].push_back({1'b1, 8'h20});
        pq[3].push_back({1'b1, 8'h23});
        kick();
        repeat (12) step();
        chk("cont_wrap_count", slog_d.size() >= 2, 1);
        if (slog_d.size() >= 1) chk("cont_wrap_hdr", slog_d[0], 8'hA0);

        // Backpressure mid-packet
        clear_logs();
        pq[1].push_back({1'b0, 8'hB0});
        pq[1].push_back({1'b0, 8'hB1});
        pq[1].push_back({1'b1, 8'hB2});
        kick();
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (slog_d.size() == 2) found = 1;
        end
        chk("bp_reach_mid", found, 1);
        rdy_pct = 0; tx_ready = 1'b0;
        #1;
        chk("bp_ready0", req_ready, 0);
        chk("bp_write0", tx_write, 0);
        for (int k = 1; k < 7; k++) begin
            step();
            #1;
            chk("bp_ready", req_ready, 0);
            chk("bp_write", tx_write, 0);
        end
        rdy_pct = 100; tx_ready = 1'b1;
        repeat (20) step();
        chk("bp_count", slog_d.size(), 4);
        if (slog_d.size() >= 4) begin
            chk("bp_hdr", slog_d[0], 8'hA1);
            chk("bp_b0", slog_d[1], 8'hB0);
            chk("bp_b1", slog_d[2], 8'hB1);
            chk("bp_b2", slog_d[3], 8'hB2);
        end

        // Timeout after header
        do_reset(); clear_logs();
        rdy_pct = 0;
        pq[1].push_back({1'b0, 8'hC0});
        pq[1].push_back({1'b1, 8'hC1});
        kick();
        repeat (3) step();
        drop[1] = 1'b1; req_valid[1] = 1'b0;
        rdy_pct = 100; tx_ready = 1'b1;
        pq[2].push_back({1'b1, 8'h5A});
        repeat (40) step();
        chk("tmo_abort_count", abort_c.size(), 1);
        chk("tmo_strobe_count", slog_d.size(), 3);
        if (slog_d.size() >= 3 && abort_c.size() >= 1) begin
            h = slog_c[0];
            chk("tmo_hdr", slog_d[0], 8'hA1);
            chk("tmo_abort_time", abort_c[0], h + 17);
            chk("tmo_busy_fell", abort_busy[0], 0);
            chk("tmo_next_hdr", slog_d[1], 8'hA2);
            chk("tmo_next_time", slog_c[1], h + 19);
            chk("tmo_next_byte", slog_d[2], 8'h5A);
        end
        drop[1] = 1'b0; pq[1].delete();

        // Asynchronous reset mid-packet
        clear_logs();
        pq[0].push_back({1'b0, 8'hD0});
        pq[0].push_back({1'b0, 8'hD1});
        pq[0].push_back({1'b0, 8'hD2});
        pq[0].push_back({1'b1, 8'hD3});
        kick();
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            #1;
            if (slog_d.size() >= 2 && tx_write) found = 1;
        end
        chk("rst_window", found, 1);
        rst = 1'b1;
        #1;
        chk("async_tx_write", tx_write, 0);
        chk("async_busy", busy, 0);
        chk("async_tx_data", tx_data, 0);
        chk("async_grant", grant_id, 0);
        chk("async_ready", req_ready, 0);
        for (int i = 0; i < N; i++) pq[i].delete();
        step(); step();
        rst = 1'b0; clear_logs();
        pq[0].push_back({1'b1, 8'hE0});
        pq[3].push_back({1'b1, 8'hE3});
        kick();
        repeat (14) step();
        chk("post_rst_count", slog_d.size(), 4);
        if (slog_d.size() >= 1) chk("post_rst_first", slog_d[0], 8'hA0);

        // No-header instance
        clear_logs();
        bq.push_back({1'b0, 8'h77});
        bq.push_back({1'b1, 8'h6F});
        kick(); c0 = cyc + 1;
        repeat (10) step();
        chk("nohdr_count", blog_d.size(), 2);
        if (blog_d.size() >= 2) begin
            chk("nohdr_b0", blog_d[0], 8'h77);
            chk("nohdr_b1", blog_d[1], 8'h6F);
            chk("nohdr_t0", blog_c[0], c0 + 2);
            chk("nohdr_t1", blog_c[1], c0 + 4);
        end
        chk("nohdr_gid", b_gid, 1);
        chk("nohdr_idle", b_busy, 0);

        // Randomized traffic
        do_reset(); clear_logs();
        vld_pct = 75; rdy_pct = 70;
        for (int p = 0; p < 30; p++) begin
            int r, len;
            r   = $urandom_range(N - 1);
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) pq[r].push_back({b == len - 1, 8'($urandom)});
        end
        kick();
        remaining = 1;
        for (int k = 0; k < 4000 && remaining != 0; k++) begin
            step();
            remaining = 0;
            for (int i = 0; i < N; i++) remaining += pq[i].size();
        end
        chk("random_drained", remaining, 0);
        repeat (6) step();
        chk("random_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
